// File: rtl/rst_sequencer.sv
// Reset release sequencer: holds all domain resets, waits for a stable lock,
// then releases one reset per gap interval in index order.
module rst_sequencer #(
    parameter int STAGES      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              LOCK_I,
    output logic [STAGES-1:0] RST_O,
    output logic              DONE_O
);

    // state     | meaning
    // ASSERT    | all resets held, counting the minimum hold time
    // WAIT_LOCK | all resets held, counting consecutive lock-high cycles
    // RELEASE   | releasing one reset bit per gap interval
    // DONE      | all resets released
    localparam logic [1:0] ST_ASSERT    = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int MAX_HL = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int MAX_C  = (MAX_HL > GAP_CYCLES) ? MAX_HL : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;
    localparam int IDX_W  = $clog2(STAGES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [STAGES-1:0] r_rst;
    logic              r_done;
    logic [STAGES-1:0] w_clear_mask;

    always_comb begin
        w_clear_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_clear_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    r_rst  <= '1;
                    r_done <= 1'b0;
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!LOCK_I) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Lock loss beats a release landing on the same edge.
                    if (!LOCK_I) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_rst   <= '1;
                        r_done  <= 1'b0;
                    end else if (r_cnt == GAP_LAST) begin
                        r_rst <= r_rst & ~w_clear_mask;
                        r_cnt <= '0;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!LOCK_I) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_rst   <= '1;
                        r_done  <= 1'b0;
                    end else begin
                        r_cnt  <= '0;
                        r_rst  <= '0;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ASSERT;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_rst   <= '1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign RST_O  = r_rst;
    assign DONE_O = r_done;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a 3-stage instance (HOLD=4, LOCK=3, GAP=2)
// and a minimal 1-stage instance (all timings 1) share the same inputs.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       lock_i;
    logic [2:0] rst_o;
    logic       done_o;
    logic [0:0] rst1_o;
    logic       done1_o;

    int n_checks = 0;
    int n_fail   = 0;

    rst_sequencer #(.STAGES(3), .HOLD_CYCLES(4), .LOCK_CYCLES(3), .GAP_CYCLES(2)) dut (
        .CLK_I (clk),
        .RST_I (rst_i),
        .LOCK_I(lock_i),
        .RST_O (rst_o),
        .DONE_O(done_o)
    );

    rst_sequencer #(.STAGES(1), .HOLD_CYCLES(1), .LOCK_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .CLK_I (clk),
        .RST_I (rst_i),
        .LOCK_I(lock_i),
        .RST_O (rst1_o),
        .DONE_O(done1_o)
    );

    always #5 clk = ~clk;

    // Three reset edges; returns just after the last one so that the next
    // rising edge with RST_I low is edge 1 of the caller's loop.
    task automatic do_reset(input logic lock);
        @(negedge clk);
        rst_i  = 1'b1;
        lock_i = lock;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        do_reset(1'b1);
        n_checks++;
        if (rst_o !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_rst_o: got %b expected %b", rst_o, 3'b111);
        end
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_o: got %b expected %b", done_o, 1'b0);
        end
        n_checks++;
        if (rst1_o !== 1'b1 || done1_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_min: got rst=%b done=%b expected rst=1 done=0", rst1_o, done1_o);
        end
    endtask

    // Lock high throughout: bits fall at edges 9, 11, 13; minimal instance at edge 3.
    task automatic test_nominal;
        logic [2:0] exp_r;
        logic       exp_d;
        do_reset(1'b1);
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            rst_i  = 1'b0;
            lock_i = 1'b1;
            @(posedge clk);
            #1;
            exp_r = {e < 13, e < 11, e < 9};
            exp_d = (e >= 13);
            n_checks++;
            if (rst_o !== exp_r || done_o !== exp_d) begin
                n_fail++;
                $display("FAIL nominal edge %0d: got rst=%b done=%b expected rst=%b done=%b",
                         e, rst_o, done_o, exp_r, exp_d);
            end
            n_checks++;
            if (rst1_o !== 1'(e < 3) || done1_o !== (e >= 3)) begin
                n_fail++;
                $display("FAIL min_cfg edge %0d: got rst=%b done=%b expected rst=%b done=%b",
                         e, rst1_o, done1_o, e < 3, e >= 3);
            end
        end
    endtask

    // Lock first sampled high at edge 8: release at 10, bits fall at 12, 14, 16.
    task automatic test_late_lock;
        logic [2:0] exp_r;
        do_reset(1'b0);
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            rst_i  = 1'b0;
            lock_i = (e >= 8);
            @(posedge clk);
            #1;
            exp_r = {e < 16, e < 14, e < 12};
            n_checks++;
            if (rst_o !== exp_r || done_o !== (e >= 16)) begin
                n_fail++;
                $display("FAIL late_lock edge %0d: got rst=%b done=%b expected rst=%b done=%b",
                         e, rst_o, done_o, exp_r, e >= 16);
            end
        end
    endtask

    // One-cycle lock glitch at edge 6 restarts the lock count: bits fall at 11, 13, 15.
    task automatic test_lock_glitch;
        logic [2:0] exp_r;
        do_reset(1'b1);
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            rst_i  = 1'b0;
            lock_i = (e != 6);
            @(posedge clk);
            #1;
            exp_r = {e < 15, e < 13, e < 11};
            n_checks++;
            if (rst_o !== exp_r || done_o !== (e >= 15)) begin
                n_fail++;
                $display("FAIL lock_glitch edge %0d: got rst=%b done=%b expected rst=%b done=%b",
                         e, rst_o, done_o, exp_r, e >= 15);
            end
        end
    endtask

    // Lock lost at edge 10 after bit 0 released: full re-hold, bits fall at 19, 21, 23.
    task automatic test_lock_loss;
        logic [2:0] exp_r;
        do_reset(1'b1);
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            rst_i  = 1'b0;
            lock_i = (e != 10);
            @(posedge clk);
            #1;
            if (e < 10) exp_r = {1'b1, 1'b1, e < 9};
            else        exp_r = {e < 23, e < 21, e < 19};
            n_checks++;
            if (rst_o !== exp_r || done_o !== (e >= 23)) begin
                n_fail++;
                $display("FAIL lock_loss edge %0d: got rst=%b done=%b expected rst=%b done=%b",
                         e, rst_o, done_o, exp_r, e >= 23);
            end
        end
    endtask

    // Reset pulse at edge rst_edge restarts everything; bits fall 9/11/13 edges later.
    task automatic test_reset_pulse(input int rst_edge, input int last_edge);
        logic [2:0] exp_r;
        int         r;
        do_reset(1'b1);
        for (int e = 1; e <= last_edge; e++) begin
            @(negedge clk);
            rst_i  = (e == rst_edge);
            lock_i = 1'b1;
            @(posedge clk);
            #1;
            r = (e < rst_edge) ? e : e - rst_edge;
            if (e == rst_edge) exp_r = 3'b111;
            else               exp_r = {r < 13, r < 11, r < 9};
            n_checks++;
            if (rst_o !== exp_r || done_o !== (e != rst_edge && r >= 13)) begin
                n_fail++;
                $display("FAIL reset_pulse@%0d edge %0d: got rst=%b done=%b expected rst=%b done=%b",
                         rst_edge, e, rst_o, done_o, exp_r, e != rst_edge && r >= 13);
            end
        end
    endtask

    initial begin
        rst_i  = 1'b1;
        lock_i = 1'b0;
        test_reset;
        test_nominal;
        test_late_lock;
        test_lock_glitch;
        test_lock_loss;
        test_reset_pulse(20, 34);
        test_reset_pulse(10, 24);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
